traffic_phase_ctrl: RTL and testbench

- Sequencing stage for a two-way intersection (NS/EW).
- Walks the light phases, counting down each phase duration on a prescaled tick.
- Emits registered light codes plus a one-cycle phase-change strobe.
- The strobe drives the load/En pins of the downstream Dflipflop register bank that holds the lamp drive bits.

---
 rtl/traffic_phase_ctrl.sv | 134 +++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer: walks NS/EW light phases on a prescaled tick.
// Define PED_WALK_EN to add the latched pedestrian request and the WALK phase.
module traffic_phase_ctrl #(
  parameter int GREEN_TIME  = 8,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 4,
  parameter int CNT_W       = 4
) (
  input  logic       Clk,
  input  logic       Clear,
  input  logic       tick,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic       phase_chg
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    WALK      = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ns_q, ns_d, ew_q, ew_d;
  logic             chg_q, chg_d;
  logic             ped_go;

  function automatic logic [CNT_W-1:0] load_val(state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   load_val = CNT_W'(GREEN_TIME - 1);
      NS_YELLOW, EW_YELLOW: load_val = CNT_W'(YELLOW_TIME - 1);
      WALK:                 load_val = CNT_W'(WALK_TIME - 1);
      default:              load_val = CNT_W'(ALLRED_TIME - 1);
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        case (state_q)
          // NS green is held at expiry until an EW car is waiting
          NS_GREEN:  if (ew_car) state_d = NS_YELLOW;
          NS_YELLOW: state_d = ALL_RED_1;
          ALL_RED_1: state_d = EW_GREEN;
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: state_d = ALL_RED_2;
          ALL_RED_2: state_d = ped_go ? WALK : NS_GREEN;
          WALK:      state_d = NS_GREEN;
          default:   state_d = ALL_RED_2;
        endcase
      end
    end
    if (state_d != state_q) cnt_d = load_val(state_d);
    chg_d = (state_d != state_q);
  end

  always_comb begin
    ns_d = 3'b100;
    ew_d = 3'b100;
    case (state_d)
      NS_GREEN:  ns_d = 3'b001;
      NS_YELLOW: ns_d = 3'b010;
      EW_GREEN:  ew_d = 3'b001;
      EW_YELLOW: ew_d = 3'b010;
      default:   ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q <= ALL_RED_2;
      cnt_q   <= CNT_W'(ALLRED_TIME - 1);
      ns_q    <= 3'b100;
      ew_q    <= 3'b100;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      chg_q   <= chg_d;
    end
  end

`ifdef PED_WALK_EN
  logic ped_pend_q, ped_pend_d;
  logic walk_q;

  // a request landing on the WALK entry cycle survives for the next loop
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (state_d == WALK && state_q != WALK) ped_pend_d = 1'b0;
    if (ped_req) ped_pend_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      walk_q     <= (state_d == WALK);
    end
  end

  assign ped_go = ped_pend_q;
  assign walk   = walk_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_go         = 1'b0;
  assign walk           = 1'b0;
`endif

  assign ns_light  = ns_q;
  assign ew_light  = ew_q;
  assign phase     = state_q;
  assign phase_chg = chg_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: a tick-level phase model pushes expected
// phase entries on every transition; a negedge monitor pops them on phase_chg.
module tb_traffic_phase_ctrl;
  localparam int GT = 8;
  localparam int YT = 3;
  localparam int AT = 1;
  localparam int WT = 4;
`ifdef PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Clear = 1'b1, tick = 1'b0, ew_car = 1'b0, ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk, phase_chg;

  traffic_phase_ctrl dut (
    .Clk(Clk), .Clear(Clear), .tick(tick), .ew_car(ew_car), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .phase(phase), .phase_chg(phase_chg)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int m_phase = 5;
  int m_rem   = AT;
  bit m_pend  = 1'b0;
  bit m_chg   = 1'b0;
  bit started = 1'b0;

  function automatic int dur(int p);
    case (p)
      0, 3:    return GT;
      1, 4:    return YT;
      6:       return WT;
      default: return AT;
    endcase
  endfunction

  // {ns[2:0], ew[2:0], walk}
  function automatic int lamps(int p);
    int ns, ew, w;
    ns = 3'b100; ew = 3'b100; w = 0;
    if (p == 0) ns = 3'b001;
    if (p == 1) ns = 3'b010;
    if (p == 3) ew = 3'b001;
    if (p == 4) ew = 3'b010;
    if (p == 6 && PED) w = 1;
    return (ns << 4) | (ew << 1) | w;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one Clk edge with the given inputs; the model tracks remaining ticks per phase
  task automatic cycle(bit clr, bit tk, bit car, bit ped);
    int nxt;
    Clear = clr; tick = tk; ew_car = car; ped_req = ped;
    @(posedge Clk);
    if (clr) begin
      m_phase = 5; m_rem = AT; m_pend = 1'b0; m_chg = 1'b0;
    end else begin
      nxt = m_phase;
      if (tk) begin
        if (m_rem > 1) m_rem--;
        else begin
          case (m_phase)
            0: nxt = car ? 1 : 0;
            5: nxt = (PED && m_pend) ? 6 : 0;
            6: nxt = 0;
            default: nxt = m_phase + 1;
          endcase
        end
      end
      if (PED) begin
        if (nxt == 6 && m_phase != 6) m_pend = 1'b0;
        if (ped) m_pend = 1'b1;
      end
      m_chg = (nxt != m_phase);
      if (m_chg) begin
        m_phase = nxt;
        m_rem   = dur(nxt);
        exp_q.push_back(nxt);
      end
    end
    started = 1'b1;
    #1;
  endtask

  initial begin
    int e;
    forever begin
      @(negedge Clk);
      if (started) begin
        chk("phase", phase, m_phase);
        chk("phase_chg", phase_chg, m_chg);
        chk("lamps", {ns_light, ew_light, walk}, lamps(m_phase));
        if (phase_chg) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_unexpected: phase_chg with phase %0d, nothing expected", phase);
          end else begin
            e = exp_q.pop_front();
            chk("sb_phase", phase, e);
            chk("sb_lamps", {ns_light, ew_light, walk}, lamps(e));
          end
        end
      end
    end
  end

  initial begin
    int n;
    bit found;
    repeat (2) cycle(1, 1, 1, 1);

    n = 0;
    for (int i = 0; i < 48; i++) begin
      cycle(0, 1, 1, 0);
      if (phase_chg) n++;
    end
    chk("period_chg_count", n, 12);

    for (int i = 0; i < 120; i++) cycle(0, (i % 4) == 3, 1, 0);

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(0, 1, 1, 0);
      if (m_phase == 0 && m_rem == 1) found = 1'b1;
    end
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0);
    chk("ext_reached", found, 1);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_phase == 4 && m_rem == 2) found = 1'b1;
      else cycle(0, 1, 1, 0);
    end
    chk("ew_yellow_cnt1_reached", found, 1);
    cycle(1, 1, 1, 1);
    for (int i = 0; i < 30; i++) cycle(0, 1, 1, 0);

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_phase == 3) found = 1'b1;
      else cycle(0, 1, 1, 0);
    end
    chk("ew_green_reached", found, 1);
    cycle(0, 1, 1, 1);
    n = 0;
    for (int i = 0; i < 48; i++) begin
      cycle(0, 1, 1, 0);
      if (walk) n++;
    end
    chk("walk_cycles", n, PED ? WT : 0);

    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);

    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
